mpfinal_sub: RTL and testbench
==============================

Name: mpfinal_sub

Overview:
- Downstream stage of the 1027-bit pipelined carry-select adder (mpadder9) in the Montgomery datapath.
- Consumes its 1028-bit sum S, with S < 2M by contract, and performs the conditional final subtraction: R = (S >= M) ? S - M : S. R is then guaranteed < M.
- Two-stage carry-select borrow pipeline with valid/ready handshakes on both sides; full throughput of one result per cycle.

Parameters:
- W, 1027, modulus/result width; the sum is W+1 bits.
- CHUNK, 64, chunk width for the borrow-select split. NCHUNK = floor((W+1)/CHUNK); the last chunk absorbs the remainder (68 bits at defaults).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  in_sum/in_mod valid
- in_ready  out  1  block can accept this cycle
- in_sum  in  W+1  sum S from the adder
- in_mod  in  W  modulus M, sampled together with in_sum
- out_valid  out  1  out_res valid
- out_ready  in  1  consumer accepts out_res
- out_res  out  W  reduced result R
- out_subbed  out  1  1 if S - M was selected

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (resetn). All state clears immediately on resetn low.
- Reset values:
  - All stage registers and valid bits are 0.
  - out_valid, out_res and out_subbed read 0.
  - in_ready reads 1 as soon as reset is released.
- Accept rule: an input is accepted when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Stage 1 (on accept), per chunk i:
  - Compute d0_i = s_i - m_i with borrow-in 0, and d1_i = s_i - m_i - 1.
  - Register d0_i, d1_i, their borrow-outs b0_i, b1_i, and s_i.
  - M is zero-extended to W+1 bits.
  - Chunk 0 needs only the borrow-in-0 variant.
- Stage 2:
  - Resolve the chain: bor_0 = b0_0; bor_i = bor_{i-1} ? b1_i : b0_i. Select d per chunk the same way.
  - Final borrow bf = bor_{NCHUNK-1}. bf = 0 means S >= M.
  - Register out_res = bf ? S[W-1:0] : D[W-1:0], and out_subbed = ~bf.
- Latency: exactly 2 cycles from accept to out_valid, when unstalled.
- Flow control:
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || adv2
  - in_ready = adv1 (combinational)
  - Stalled stages hold their data unchanged.
- Boundary cases:
  - S == M gives R = 0, subbed = 1.
  - S == M - 1 gives R = M - 1, subbed = 0.
  - A borrow crossing every chunk boundary must resolve correctly.
  - Simultaneous accept and output drain in the same cycle must keep throughput at 1/cycle.
  - S >= 2M is outside the contract: the output is S - M truncated to W bits, with no flag.
  - Reset asserted mid-operation discards all in-flight results; no output appears after reset release.

Optional Feature:
- Macro: MPFINAL_SUB_CNT_EN.
- When defined:
  - Adds output sub_cnt [31:0], reset to 0.
  - Increments on each output transfer with out_subbed = 1.
  - Saturates at 32'hFFFFFFFF.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mp_pkg holds:
  - constants MP_W = 1027 and MP_CHUNK = 64;
  - the derived NCHUNK and last-chunk width;
  - the typedef for the W+1-bit sum.
- One sub-module: sub_chunk_dual, a parameterised-width chunk subtractor. It outputs d0/b0 (borrow-in 0) and d1/b1 (borrow-in 1) and is instantiated NCHUNK times in stage 1.

Test Plan:
- M = 13, S = 20 → R = 7, subbed = 1; S = 12 → R = 12, subbed = 0; S = 13 → R = 0, subbed = 1. Each appears exactly 2 cycles after accept.
- M = 1, S = 2^64 → R = 2^64 - 1 (borrow crosses chunk 0→1). M = 1, S = 2^960 → R = 2^960 - 1 (borrow ripples through every chunk).
- M = 2^1026 + 5, S = 2^1027 + 3 → R = 2^1026 - 2, subbed = 1 (top 68-bit chunk exercised).
- 10 back-to-back inputs with out_ready = 1 → 10 in-order outputs on consecutive cycles. Then 3 inputs with out_ready = 0 for 5 cycles → in_ready drops after 2 accepts; outputs resume in order with no loss or duplication.
- resetn pulsed low while 2 results are in flight → out_valid = 0 immediately; nothing emerges afterwards; a fresh input produces the correct R 2 cycles after accept.
- With MPFINAL_SUB_CNT_EN defined: 4 subtracting and 3 non-subtracting transfers → sub_cnt = 4. A stalled (untransferred) output does not increment the counter.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared constants and types for the Montgomery final-subtraction datapath.
// Chunking splits the W+1-bit sum into equal chunks; the last one takes the remainder.
package mp_pkg;

  localparam int MP_W      = 1027;
  localparam int MP_CHUNK  = 64;
  localparam int MP_NCHUNK = (MP_W + 1) / MP_CHUNK;
  localparam int MP_LAST_W = (MP_W + 1) - (MP_NCHUNK - 1) * MP_CHUNK;

  typedef logic [MP_W:0] mp_sum_t;

  // Width of chunk idx for a sum of sw bits split into n chunks of cw bits.
  function automatic int chunkWidth(input int idx, input int sw, input int cw, input int n);
    return (idx == n - 1) ? (sw - idx * cw) : cw;
  endfunction

endpackage

// File: rtl/sub_chunk_dual.sv
// One chunk of the borrow-select subtractor.
// It produces a-b and a-b-1 together with their borrow-outs.
module sub_chunk_dual #(
  parameter int CW = 64
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  output logic [CW-1:0] o_d0,
  output logic          o_b0,
  output logic [CW-1:0] o_d1,
  output logic          o_b1
);

  logic [CW:0] w_diff0;
  logic [CW:0] w_diff1;

  // The extra top bit of each difference is the borrow-out of the chunk.
  assign w_diff0 = {1'b0, i_a} - {1'b0, i_b};
  assign w_diff1 = {1'b0, i_a} - {1'b0, i_b} - (CW+1)'(1);

  assign o_d0 = w_diff0[CW-1:0];
  assign o_b0 = w_diff0[CW];
  assign o_d1 = w_diff1[CW-1:0];
  assign o_b1 = w_diff1[CW];

endmodule

// File: rtl/mpfinal_sub.sv
// Conditional final subtraction R = (S >= M) ? S - M : S in a two-stage borrow-select pipeline.
// Optional build macro MPFINAL_SUB_CNT_EN adds a saturating sub_cnt output of subtracting transfers.
module mpfinal_sub
  import mp_pkg::*;
#(
  parameter int W     = MP_W,
  parameter int CHUNK = MP_CHUNK
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_sum,
  input  logic [W-1:0] in_mod,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_subbed
`ifdef MPFINAL_SUB_CNT_EN
  ,
  output logic [31:0]  sub_cnt
`endif
);

  localparam int SW     = W + 1;
  localparam int NCHUNK = SW / CHUNK;

  logic [SW-1:0]     w_mod;
  logic [SW-1:0]     w_d0;
  logic [SW-1:0]     w_d1;
  logic [NCHUNK-1:0] w_b0;
  logic [NCHUNK-1:0] w_b1;
  logic [NCHUNK:0]   w_bor;
  logic [SW-1:0]     w_d;
  logic              w_bf;
  logic              w_adv1;
  logic              w_adv2;
  logic              w_unused;

  logic              r_v1;
  logic [SW-1:0]     r_s;
  logic [SW-1:0]     r_d0;
  logic [SW-1:0]     r_d1;
  logic [NCHUNK-1:0] r_b0;
  logic [NCHUNK-1:0] r_b1;
  logic              r_v2;
  logic [W-1:0]      r_res;
  logic              r_subbed;

  assign w_mod  = {1'b0, in_mod};
  assign w_adv2 = !r_v2 || out_ready;
  assign w_adv1 = !r_v1 || w_adv2;

  // Borrow into chunk 0 is zero, so its borrow-in-1 variant is never selected.
  assign w_bor[0] = 1'b0;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
    localparam int LO = i * CHUNK;
    localparam int CW = chunkWidth(i, SW, CHUNK, NCHUNK);

    sub_chunk_dual #(.CW(CW)) u_sub (
      .i_a  (in_sum[LO +: CW]),
      .i_b  (w_mod[LO +: CW]),
      .o_d0 (w_d0[LO +: CW]),
      .o_b0 (w_b0[i]),
      .o_d1 (w_d1[LO +: CW]),
      .o_b1 (w_b1[i])
    );

    assign w_bor[i+1]     = w_bor[i] ? r_b1[i] : r_b0[i];
    assign w_d[LO +: CW]  = w_bor[i] ? r_d1[LO +: CW] : r_d0[LO +: CW];
  end

  assign w_bf = w_bor[NCHUNK];

  // Bit W of the sum and difference never reaches the W-bit result.
  assign w_unused = ^{r_s[W], w_d[W]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v1     <= 1'b0;
      r_s      <= '0;
      r_d0     <= '0;
      r_d1     <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
      r_v2     <= 1'b0;
      r_res    <= '0;
      r_subbed <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_s  <= in_sum;
          r_d0 <= w_d0;
          r_d1 <= w_d1;
          r_b0 <= w_b0;
          r_b1 <= w_b1;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_res    <= w_bf ? r_s[W-1:0] : w_d[W-1:0];
          r_subbed <= ~w_bf;
        end
      end
    end
  end

  assign in_ready   = w_adv1;
  assign out_valid  = r_v2;
  assign out_res    = r_res;
  assign out_subbed = r_subbed;

`ifdef MPFINAL_SUB_CNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_v2 && out_ready && r_subbed && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign sub_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_mpfinal_sub.sv
// Scoreboard bench for mpfinal_sub: a driver pushes model results, a monitor pops on each transfer.
// Also exercises the MPFINAL_SUB_CNT_EN counter when that macro is defined.
module tb_mpfinal_sub;
  import mp_pkg::*;

  localparam int W = MP_W;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  mp_sum_t      in_sum = '0;
  logic [W-1:0] in_mod = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic         out_subbed;
`ifdef MPFINAL_SUB_CNT_EN
  logic [31:0]  sub_cnt;
  int           expCnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         subbed;
    int           acc;
    bit           chkLat;
  } exp_t;

  exp_t sb[$];
  bit   headSeen = 1'b0;

  mpfinal_sub dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_mod     (in_mod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_subbed (out_subbed)
`ifdef MPFINAL_SUB_CNT_EN
    ,
    .sub_cnt    (sub_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h (low 128 bits) at %0t", name, act[127:0], exp[127:0], $time);
    end
  endtask

  // Reference: plain wide arithmetic on the full sum.
  function automatic exp_t refModel(input mp_sum_t s, input logic [W-1:0] m);
    exp_t    e;
    mp_sum_t mz;
    mp_sum_t diff;
    mz       = {1'b0, m};
    diff     = s - mz;
    e.subbed = (s >= mz);
    e.res    = e.subbed ? diff[W-1:0] : s[W-1:0];
    e.acc    = 0;
    e.chkLat = 1'b0;
    return e;
  endfunction

  function automatic mp_sum_t randWide();
    logic [1055:0] t;
    for (int k = 0; k < 33; k++) t[k*32 +: 32] = $urandom;
    return t[W:0];
  endfunction

  function automatic logic [W-1:0] randMod();
    mp_sum_t      t;
    logic [W-1:0] m;
    t = randWide();
    m = t[W-1:0];
    m = m >> $urandom_range(0, 1000);
    if (m == '0) m = 1;
    return m;
  endfunction

  // Mostly in-contract sums, with extra weight on the S == M neighbourhood.
  function automatic mp_sum_t randSum(input logic [W-1:0] m);
    mp_sum_t mz;
    mp_sum_t d;
    int      mode;
    mz   = {1'b0, m};
    mode = $urandom_range(0, 3);
    d    = mp_sum_t'($urandom_range(0, 3));
    if (mode == 1) return mz + d;
    if (mode == 2 && mz > d) return mz - d - mp_sum_t'(1);
    return randWide() % (mz << 1);
  endfunction

  // Present one input and hold it until accepted; the expected result is queued at accept time.
  task automatic applyStimulus(input mp_sum_t s, input logic [W-1:0] m, input bit chkLat);
    exp_t e;
    int   waitCnt;
    bit   done;
    e        = refModel(s, m);
    e.chkLat = chkLat;
    in_sum   = s;
    in_mod   = m;
    in_valid = 1'b1;
    done     = 1'b0;
    waitCnt  = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cycle;
        sb.push_back(e);
        done = 1'b1;
      end else if (++waitCnt > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL acceptTimeout got in_ready=0 for %0d cycles expected acceptance", waitCnt);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout got %0d pending results expected 0", sb.size());
      sb.delete();
      headSeen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the head of the scoreboard whenever a transfer is about to happen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedOutput got out_valid=1 expected 0 at %0t", $time);
        end else begin
          e = sb[0];
          if (!headSeen) begin
            headSeen = 1'b1;
            if (e.chkLat) checkOutput("latency", (W+1)'(cycle - e.acc), (W+1)'(2));
          end
          if (out_ready) begin
            checkOutput("result", {1'b0, out_res}, {1'b0, e.res});
            checkOutput("subbed", (W+1)'(out_subbed), (W+1)'(e.subbed));
`ifdef MPFINAL_SUB_CNT_EN
            if (e.subbed) expCnt++;
`endif
            void'(sb.pop_front());
            headSeen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    mp_sum_t      s;
    logic [W-1:0] m;
    bit           randDone;

    out_ready = 1'b1;
    resetn    = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    @(negedge clk);
    checkOutput("rstOutValid", (W+1)'(out_valid), (W+1)'(0));
    checkOutput("rstOutRes", {1'b0, out_res}, '0);
    checkOutput("rstSubbed", (W+1)'(out_subbed), (W+1)'(0));
    checkOutput("rstInReady", (W+1)'(in_ready), (W+1)'(1));
`ifdef MPFINAL_SUB_CNT_EN
    checkOutput("rstSubCnt", (W+1)'(sub_cnt), (W+1)'(0));
`endif
    @(posedge clk);
    #1;

    $display("[TB] directed small and chunk-boundary cases");
    m = 13;
    applyStimulus(mp_sum_t'(20), m, 1'b1);
    applyStimulus(mp_sum_t'(12), m, 1'b1);
    applyStimulus(mp_sum_t'(13), m, 1'b1);
    m = 1;
    s = '0; s[64] = 1'b1;
    applyStimulus(s, m, 1'b1);
    s = '0; s[960] = 1'b1;
    applyStimulus(s, m, 1'b1);
    m = '0; m[W-1] = 1'b1; m[2:0] = 3'd5;
    s = '0; s[W] = 1'b1; s[1:0] = 2'd3;
    applyStimulus(s, m, 1'b1);
    m = randMod();
    applyStimulus({1'b0, m} - mp_sum_t'(1), m, 1'b1);
    applyStimulus({1'b0, m}, m, 1'b1);
    waitDrain();

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 10; i++) begin
      m = randMod();
      applyStimulus(randSum(m), m, 1'b1);
    end
    waitDrain();

    $display("[TB] output stall");
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m = randMod();
      applyStimulus(randSum(m), m, 1'b0);
    end
    @(negedge clk);
    checkOutput("stallInReady", (W+1)'(in_ready), (W+1)'(0));
    @(posedge clk);
    #1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    m = randMod();
    applyStimulus(randSum(m), m, 1'b0);
    waitDrain();

    $display("[TB] reset with results in flight");
    m = randMod();
    applyStimulus(randSum(m), m, 1'b0);
    applyStimulus(randSum(m), m, 1'b0);
    resetn = 1'b0;
    #1;
    checkOutput("rstMidValid", (W+1)'(out_valid), (W+1)'(0));
    sb.delete();
    headSeen = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("postRstIdle", (W+1)'(out_valid), (W+1)'(0));
    @(posedge clk);
    #1;
    m = 13;
    applyStimulus(mp_sum_t'(20), m, 1'b1);
    waitDrain();
`ifdef MPFINAL_SUB_CNT_EN
    expCnt = 1;
`endif

    $display("[TB] randomized traffic with random backpressure");
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          m = randMod();
          applyStimulus(randSum(m), m, 1'b0);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();

`ifdef MPFINAL_SUB_CNT_EN
    @(negedge clk);
    checkOutput("subCnt", (W+1)'(sub_cnt), (W+1)'(expCnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
